barrel_right_pipe: RTL and testbench
====================================

Name: barrel_right_pipe

Overview:
- 16-bit right barrel shifter for the ALU shift unit.
- Four pipeline stages, one per shift-amount bit. Stage k shifts right by 2^k when shft[k] is set.
- Valid/ready handshake on both input and output, so the ALU issue logic can stall it.
- Supports logical and arithmetic right shift. Rotate-right is an optional build feature.

Parameters:
- WIDTH, 16, data width; fixed at 16, and the shift amount is log2(WIDTH) = 4 bits.
- STAGES, 4, pipeline depth; must equal log2(WIDTH).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data, shft and mode are valid this cycle.
- in_ready  output  1  shifter can accept an operand this cycle.
- in_data  input  16  operand.
- shft  input  4  shift amount, 0..15.
- mode  input  2  00 logical, 01 arithmetic, 10 rotate (ROTATE_EN only), 11 reserved.
- out_valid  output  1  out_data and out_zero are valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  16  shifted result.
- out_zero  output  1  set when out_data == 16'h0000.

Behaviour:
- Reset (rst_n low, asynchronous): every stage valid bit, data register, shift-amount register and mode register clears to 0. Outputs after reset:
  - out_valid = 0, out_data = 16'h0000, out_zero = 0.
  - in_ready = 1 in the first cycle after rst_n deasserts.
- Input transfer happens when in_valid && in_ready. Output transfer happens when out_valid && out_ready.
- Stage registers:
  - Stage k (k = 0..3) holds valid_k, data_k, the remaining shft bits and mode.
  - Stage k loads from stage k-1 (stage 0 loads from the inputs) when !valid_k || advance_k.
  - advance_3 = out_ready. advance_k = !valid_(k+1) || advance_(k+1).
  - in_ready = !valid_0 || advance_0. This is combinational from out_ready; there is no skid buffer.
- Stage k shift rule, applied when the registered shft[k] = 1 (otherwise data passes unchanged):
  - Logical: data >> 2^k, vacated MSBs filled with 0.
  - Arithmetic: vacated MSBs filled with the sign bit of the stage input. The sign bit is preserved through every stage.
  - Rotate: the low 2^k bits wrap into the MSBs.
  - Reserved mode 11: treated as logical.
- Timing:
  - Latency is 4 cycles, input transfer to out_valid, when there is no backpressure.
  - Throughput is 1 result per cycle while out_ready = 1.
- out_data is the stage-3 data register; out_zero is registered alongside it. Both hold stable while out_valid && !out_ready.
- Boundary conditions:
  - shft = 0: the operand passes through unchanged in every mode, still with 4-cycle latency.
  - shft = 15: logical leaves bit 0 = in_data[15]; arithmetic gives all bits = in_data[15].
  - Full pipeline with out_ready = 0: in_ready = 0 and no stage changes.
  - Same-cycle pop and push on a full pipeline: the whole pipe advances by one, with no bubble and no loss.
  - Empty pipeline: out_valid = 0, and out_data keeps its last value (not required to be zero).
  - Reset mid-operation: all in-flight operands are discarded, and no out_valid pulse occurs after rst_n rises until a new input has been accepted.

Optional Feature:
- Macro: BARREL_ROTATE_EN.
- Defined: mode 10 performs rotate-right by shft.
- Undefined: mode 10 behaves as logical, and the rotate datapath is not synthesized.

Decomposition:
- Shared package holds:
  - The mode encodings: SHR_LOGIC = 2'b00, SHR_ARITH = 2'b01, SHR_ROT = 2'b10.
  - The constants WIDTH = 16 and SHAMT_W = 4.
- One sub-module, shr_stage: one stage's 2:1 shift mux plus its pipeline register and valid/advance logic. It has a parameter DIST = 1, 2, 4 or 8 and is instantiated four times.

Test Plan:
- Logical, shft = 1, in_data = 16'h8001 -> out_data = 16'h4000, out_zero = 0, out_valid exactly 4 cycles after the transfer.
- Arithmetic:
  - shft = 4, in_data = 16'h8000 -> 16'hF800.
  - shft = 15, in_data = 16'h7FFF -> 16'h0000 with out_zero = 1.
- Edge amounts, logical: shft = 0, 16'hA5A5 -> 16'hA5A5; shft = 15, 16'hFFFF -> 16'h0001.
- Backpressure:
  - Stream 6 operands (16'h0010 >> 0..5) with out_ready held 0 for 3 cycles mid-stream.
  - Required: in_ready drops after 4 operands are in flight; all 6 results (16'h0010, 8, 4, 2, 1, 0) appear in order with none lost or duplicated.
- Reset mid-flight: accept 3 operands, assert rst_n low for 1 cycle -> out_valid stays 0 and the next accepted operand is the first result out.
- With BARREL_ROTATE_EN, mode 10:
  - shft = 1, 16'h0001 -> 16'h8000.
  - shft = 8, 16'h12AB -> 16'hAB12.
  - Without the macro, the same shft = 1, 16'h0001 stimulus -> 16'h0000.

Source files
------------

// File: rtl/barrel_right_pipe_pkg.sv
// Shared constants and shift-mode encodings for the pipelined right barrel shifter.
// Optional rotate datapath is enabled by defining BARREL_ROTATE_EN.
package barrel_right_pipe_pkg;

  localparam int WIDTH   = 16;
  localparam int SHAMT_W = 4;
  localparam int STAGES  = SHAMT_W;

  typedef enum logic [1:0] {
    SHR_LOGIC = 2'b00,
    SHR_ARITH = 2'b01,
    SHR_ROT   = 2'b10,
    SHR_RSVD  = 2'b11
  } shr_mode_t;

endpackage

// File: rtl/barrel_right_pipe_if.sv
// Operand/result handshake bundle for barrel_right_pipe (valid/ready on both sides).
// Unaffected by BARREL_ROTATE_EN; mode 2'b10 is simply passed through.
interface barrel_right_pipe_if;
  import barrel_right_pipe_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] shft;
  logic [1:0]         mode;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_zero;

  modport master (
    output in_valid, in_data, shft, mode, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );

  modport slave (
    input  in_valid, in_data, shft, mode, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );

endinterface

// File: rtl/barrel_right_pipe_shr_stage.sv
// One shifter stage: conditional right shift by DIST plus its pipeline register.
// Rotate fill is only built when BARREL_ROTATE_EN is defined.
module shr_stage
  import barrel_right_pipe_pkg::*;
#(
  parameter int DIST = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               up_valid,
  input  logic [WIDTH-1:0]   up_data,
  input  logic [SHAMT_W-1:0] up_shft,
  input  logic [1:0]         up_mode,
  input  logic               advance,
  output logic               load,
  output logic               valid,
  output logic [WIDTH-1:0]   data,
  output logic [SHAMT_W-1:0] shft,
  output logic [1:0]         mode,
  output logic [WIDTH-1:0]   result
);

  localparam int SHIFT_BIT = $clog2(DIST);

  logic [WIDTH-1:0] fill;

  // The top DIST bits come from the fill word: zeros, the sign, or the operand itself (rotate).
  always_comb begin
    fill = '0;
    if (up_mode == SHR_ARITH) begin
      fill = {WIDTH{up_data[WIDTH-1]}};
    end
`ifdef BARREL_ROTATE_EN
    else if (up_mode == SHR_ROT) begin
      fill = up_data;
    end
`endif
    result = up_data;
    if (up_shft[SHIFT_BIT]) begin
      result = {fill[DIST-1:0], up_data[WIDTH-1:DIST]};
    end
  end

  assign load = !valid || advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      shft  <= '0;
      mode  <= '0;
    end else if (load) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= result;
        shft <= up_shft;
        mode <= up_mode;
      end
    end
  end

endmodule

// File: rtl/barrel_right_pipe.sv
// Four-stage 16-bit right barrel shifter (logical/arithmetic) with valid/ready on both ends.
// Define BARREL_ROTATE_EN to make mode 2'b10 rotate right instead of shifting logically.
module barrel_right_pipe
  import barrel_right_pipe_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  barrel_right_pipe_if.slave  bus
);

  logic               st_valid  [STAGES];
  logic               st_load   [STAGES];
  logic [WIDTH-1:0]   st_data   [STAGES];
  logic [SHAMT_W-1:0] st_shft   [STAGES];
  logic [1:0]         st_mode   [STAGES];
  logic [WIDTH-1:0]   st_result [STAGES];
  logic               zero_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic               up_valid;
    logic [WIDTH-1:0]   up_data;
    logic [SHAMT_W-1:0] up_shft;
    logic [1:0]         up_mode;
    logic               adv;

    if (k == 0) begin : g_head
      assign up_valid = bus.in_valid;
      assign up_data  = bus.in_data;
      assign up_shft  = bus.shft;
      assign up_mode  = bus.mode;
    end else begin : g_body
      assign up_valid = st_valid[k-1];
      assign up_data  = st_data[k-1];
      assign up_shft  = st_shft[k-1];
      assign up_mode  = st_mode[k-1];
    end

    // A stage may move on when the next one is empty or itself moving; the last one follows out_ready.
    if (k == STAGES - 1) begin : g_tail
      assign adv = bus.out_ready;
    end else begin : g_mid
      assign adv = st_load[k+1];
    end

    shr_stage #(.DIST(1 << k)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (up_valid),
      .up_data  (up_data),
      .up_shft  (up_shft),
      .up_mode  (up_mode),
      .advance  (adv),
      .load     (st_load[k]),
      .valid    (st_valid[k]),
      .data     (st_data[k]),
      .shft     (st_shft[k]),
      .mode     (st_mode[k]),
      .result   (st_result[k])
    );
  end

  // Zero flag is registered with the final data so both hold together under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
    end else if (st_load[STAGES-1] && st_valid[STAGES-2]) begin
      zero_q <= (st_result[STAGES-1] == '0);
    end
  end

  assign bus.in_ready  = st_load[0];
  assign bus.out_valid = st_valid[STAGES-1];
  assign bus.out_data  = st_data[STAGES-1];
  assign bus.out_zero  = zero_q;

endmodule

// File: tb/tb_barrel_right_pipe.sv
// Bench for barrel_right_pipe: directed cases, backpressure, mid-flight reset and random traffic
// against a queue-based reference model; rotate expectations follow BARREL_ROTATE_EN.
module tb_barrel_right_pipe;

  logic clk;
  logic rst_n;

  barrel_right_pipe_if bus ();

  barrel_right_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] q[$];
  logic        stalledPrev = 1'b0;
  logic [15:0] stalledData = 16'h0;

  logic        sv;
  logic [15:0] sd;
  logic        sz;
  logic        sp;

  function automatic logic [15:0] refShift(input logic [15:0] d, input logic [3:0] s,
                                           input logic [1:0] m);
    int          sgn;
    logic [31:0] rot;
    rot = 32'h0;
    case (m)
      2'b01: begin
        sgn = d[15] ? int'(d) - 65536 : int'(d);
        return 16'(sgn >>> s);
      end
`ifdef BARREL_ROTATE_EN
      2'b10: begin
        rot = {d, d} >> s;
        return rot[15:0];
      end
`endif
      default: return d >> s;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, settle, check against the model, then cross the rising edge.
  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic [3:0] s,
                               input logic [1:0] m, input logic r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.shft      = s;
    bus.mode      = m;
    bus.out_ready = r;
    #1;
    checkOutput("in_ready", bus.in_ready, (r || q.size() < 4));
    if (stalledPrev) begin
      checkOutput("hold_valid", bus.out_valid, 1'b1);
      checkOutput("hold_data", bus.out_data, stalledData);
    end
    sv = bus.out_valid;
    sd = bus.out_data;
    sz = bus.out_zero;
    if (bus.out_valid === 1'b1) begin
      checkOutput("spurious_valid", (q.size() > 0), 1'b1);
      if (q.size() > 0) begin
        checkOutput("out_data", bus.out_data, q[0]);
        checkOutput("out_zero", bus.out_zero, (q[0] == 16'h0));
        if (r) void'(q.pop_front());
      end
    end
    stalledPrev = (bus.out_valid === 1'b1) && !r;
    stalledData = bus.out_data;
    sp = v && (bus.in_ready === 1'b1);
    if (sp) q.push_back(refShift(d, s, m));
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic [15:0] d, input logic [3:0] s,
                          input logic [1:0] m, input logic [15:0] expData, input logic expZero);
    int          seenAt;
    logic [15:0] gotD;
    logic        gotZ;
    seenAt = 0;
    gotD   = 16'h0;
    gotZ   = 1'b0;
    applyStimulus(1'b1, d, s, m, 1'b1);
    checkOutput({tag, "_accept"}, sp, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1'b0, 16'h0, 4'h0, 2'b00, 1'b1);
      if (sv === 1'b1 && seenAt == 0) begin
        seenAt = i;
        gotD   = sd;
        gotZ   = sz;
      end
    end
    checkOutput({tag, "_latency"}, seenAt, 4);
    checkOutput({tag, "_data"}, gotD, expData);
    checkOutput({tag, "_zero"}, gotZ, expZero);
  endtask

  logic [15:0] expList [6] = '{16'h0010, 16'h0008, 16'h0004, 16'h0002, 16'h0001, 16'h0000};
  logic [15:0] got[$];

  initial begin
    int          idx;
    logic        sawStall;
    logic        v;
    logic        r;
    logic [15:0] d;
    logic [3:0]  s;
    logic [1:0]  m;

    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0;
    bus.shft      = 4'h0;
    bus.mode      = 2'b00;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", bus.out_valid, 1'b0);
    checkOutput("rst_out_data", bus.out_data, 16'h0000);
    checkOutput("rst_out_zero", bus.out_zero, 1'b0);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;

    $display("[TB] directed shifts");
    directed("log1",   16'h8001, 4'd1,  2'b00, 16'h4000, 1'b0);
    directed("ar4",    16'h8000, 4'd4,  2'b01, 16'hF800, 1'b0);
    directed("ar15",   16'h7FFF, 4'd15, 2'b01, 16'h0000, 1'b1);
    directed("ar15n",  16'h8001, 4'd15, 2'b01, 16'hFFFF, 1'b0);
    directed("log0",   16'hA5A5, 4'd0,  2'b00, 16'hA5A5, 1'b0);
    directed("ar0",    16'hA5A5, 4'd0,  2'b01, 16'hA5A5, 1'b0);
    directed("log15",  16'hFFFF, 4'd15, 2'b00, 16'h0001, 1'b0);
    directed("rsvd3",  16'h8000, 4'd3,  2'b11, 16'h1000, 1'b0);
`ifdef BARREL_ROTATE_EN
    directed("rot1",   16'h0001, 4'd1,  2'b10, 16'h8000, 1'b0);
    directed("rot8",   16'h12AB, 4'd8,  2'b10, 16'hAB12, 1'b0);
`else
    directed("rot1off", 16'h0001, 4'd1, 2'b10, 16'h0000, 1'b1);
    directed("rot8off", 16'h12AB, 4'd8, 2'b10, 16'h0012, 1'b0);
`endif

    $display("[TB] backpressure stream");
    idx      = 0;
    sawStall = 1'b0;
    for (int cyc = 0; cyc < 40 && got.size() < 6; cyc++) begin
      r = !(cyc >= 2 && cyc <= 4);
      v = (idx < 6);
      applyStimulus(v, 16'h0010, 4'(idx), 2'b00, r);
      if (v && !sp) sawStall = 1'b1;
      if (sp) idx++;
      if (sv === 1'b1 && r) got.push_back(sd);
    end
    checkOutput("bp_stall", sawStall, 1'b1);
    checkOutput("bp_count", got.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < got.size()) checkOutput($sformatf("bp_res%0d", i), got[i], expList[i]);
    end

    $display("[TB] reset mid-flight");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'hFFFF, 4'(i), 2'b00, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    stalledPrev = 1'b0;
    checkOutput("rst_mid_valid", bus.out_valid, 1'b0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 16'h0, 4'h0, 2'b00, 1'b1);
      checkOutput("rst_quiet", sv, 1'b0);
    end
    directed("rst_first", 16'h1234, 4'd4, 2'b00, 16'h0123, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      s = 4'($urandom_range(0, 15));
      m = 2'($urandom_range(0, 3));
      applyStimulus(v, d, s, m, r);
    end
    for (int i = 0; i < 40 && q.size() > 0; i++) applyStimulus(1'b0, 16'h0, 4'h0, 2'b00, 1'b1);
    checkOutput("drain_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
